// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester round-robin arbiter for a single-port sync-read RAM
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [DATA_W/8-1:0]   be_0,
  input  logic [ADDR_W-1:0]     addr_0,
  input  logic [DATA_W-1:0]     wdata_0,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [DATA_W/8-1:0]   be_1,
  input  logic [ADDR_W-1:0]     addr_1,
  input  logic [DATA_W-1:0]     wdata_1,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_prio, w_prio_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic [1:0] r_rd_pend;
  logic       w_gnt0, w_gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_hold_cnt <= 8'd0;
      r_rd_pend  <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rd_pend  <= {w_gnt1 & ~we_1, w_gnt0 & ~we_0};
    end
  end

  // Every hand-over (including entry from IDLE) restarts the tenure count and
  // gives the tie-break to the requester that lost.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (req_0 && (!req_1 || !r_prio)) begin
          w_gnt0      = 1'b1;
          w_state_nxt = OWN0;
          w_hold_nxt  = 8'd0;
          w_prio_nxt  = 1'b1;
        end else if (req_1) begin
          w_gnt1      = 1'b1;
          w_state_nxt = OWN1;
          w_hold_nxt  = 8'd0;
          w_prio_nxt  = 1'b0;
        end
      end
      OWN0: begin
        if (!req_0) begin
          if (req_1) begin
            w_gnt1      = 1'b1;
            w_state_nxt = OWN1;
            w_hold_nxt  = 8'd0;
            w_prio_nxt  = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (!req_1 || (r_hold_cnt < c_hold_last)) begin
          w_gnt0 = 1'b1;
          if (r_hold_cnt < c_hold_last) w_hold_nxt = r_hold_cnt + 8'd1;
        end else begin
          w_gnt1      = 1'b1;
          w_state_nxt = OWN1;
          w_hold_nxt  = 8'd0;
          w_prio_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!req_1) begin
          if (req_0) begin
            w_gnt0      = 1'b1;
            w_state_nxt = OWN0;
            w_hold_nxt  = 8'd0;
            w_prio_nxt  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (!req_0 || (r_hold_cnt < c_hold_last)) begin
          w_gnt1 = 1'b1;
          if (r_hold_cnt < c_hold_last) w_hold_nxt = r_hold_cnt + 8'd1;
        end else begin
          w_gnt0      = 1'b1;
          w_state_nxt = OWN0;
          w_hold_nxt  = 8'd0;
          w_prio_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign gnt_0     = w_gnt0;
  assign gnt_1     = w_gnt1;
  assign ram_en    = w_gnt0 | w_gnt1;
  assign ram_we    = (w_gnt1 && we_1) ? be_1 :
                     (w_gnt0 && we_0) ? be_0 : '0;
  assign ram_addr  = w_gnt1 ? addr_1  : addr_0;
  assign ram_wdata = w_gnt1 ? wdata_1 : wdata_0;
  assign rvalid_0  = r_rd_pend[0];
  assign rvalid_1  = r_rd_pend[1];
  assign rdata     = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural RAM model
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_0, req_1, we_0, we_1;
  logic [BE_W-1:0]   be_0, be_1, ram_we;
  logic [ADDR_W-1:0] addr_0, addr_1, ram_addr;
  logic [DATA_W-1:0] wdata_0, wdata_1, rdata, ram_wdata, ram_rdata;
  logic              gnt_0, gnt_1, rvalid_0, rvalid_1, ram_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .be_0(be_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0),
    .req_1(req_1), .we_1(we_1), .be_1(be_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port synchronous-read RAM
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < BE_W; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_0 = 1'b0;
    req_1 = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- reference model (tenure-length view) ----------------
  int                m_owner;
  int                m_len;
  int                m_prio;
  logic [1:0]        m_rv;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rd_ok;
  logic [DATA_W-1:0] ref_mem [0:15];
  logic              ref_ok  [0:15];

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_prio  = 0;
    m_rv    = 2'b00;
    m_rd_ok = 1'b0;
    m_rdata = '0;
    for (int i = 0; i < 16; i++) ref_ok[i] = 1'b0;
  endtask

  function automatic int pick();
    logic [1:0] r;
    int o;
    r = {req_1, req_0};
    if (m_owner < 0) begin
      if (r == 2'b11) return m_prio;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
    end
    o = m_owner;
    if (!r[o]) return r[1-o] ? 1 - o : -1;
    if (r[1-o] && m_len >= MAX_HOLD) return 1 - o;
    return o;
  endfunction

  task automatic rcheck(output int w);
    logic [1:0]        eg;
    logic              ewr;
    logic [BE_W-1:0]   ewe;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    to_check();
    w   = pick();
    eg  = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    ewr = (w == 1) ? we_1 : we_0;
    ea  = (w == 1) ? addr_1 : addr_0;
    ed  = (w == 1) ? wdata_1 : wdata_0;
    ewe = ewr ? ((w == 1) ? be_1 : be_0) : '0;
    chk("rnd_gnt", 64'({gnt_1, gnt_0}), 64'(eg));
    if (w >= 0)
      chk("rnd_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({1'b1, ewe, ea, ed}));
    else
      chk("rnd_idle", 64'({ram_en, ram_we}), 64'd0);
    chk("rnd_rvalid", 64'({rvalid_1, rvalid_0}), 64'(m_rv));
    if (m_rv != 2'b00 && m_rd_ok) chk("rnd_rdata", 64'(rdata), 64'(m_rdata));
    m_rv = 2'b00;
    if (w >= 0) begin
      if (!ewr) begin
        m_rv    = (w == 1) ? 2'b10 : 2'b01;
        m_rdata = ref_mem[ea[3:0]];
        m_rd_ok = ref_ok[ea[3:0]];
      end else begin
        for (int b = 0; b < BE_W; b++)
          if (ewe[b]) ref_mem[ea[3:0]][8*b +: 8] = ed[8*b +: 8];
        if (ewe == '1) ref_ok[ea[3:0]] = 1'b1;
      end
      if (w == m_owner) m_len++;
      else begin
        m_owner = w;
        m_len   = 1;
        m_prio  = 1 - w;
      end
    end else begin
      m_owner = -1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       r0, r1, w0, w1;
    logic [1:0] g;
    logic [1:0] rv;
  } vec_t;

  vec_t vec [0:19];

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vec[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00};
    vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01};
    vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01};
    vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01};
    vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01};
    vec[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10};
    vec[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10};
    vec[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10};
    vec[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
    vec[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00};
    vec[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vec[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00};
    vec[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};

    rst = 1'b0;
    req_0 = 1'b0; we_0 = 1'b0; be_0 = '0; addr_0 = '0; wdata_0 = '0;
    req_1 = 1'b0; we_1 = 1'b0; be_1 = '0; addr_1 = '0; wdata_1 = '0;
    #1;
    chk("reset_out", 64'({gnt_1, gnt_0, rvalid_1, rvalid_0, ram_en}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single read from M0 (word preloaded through the arbiter first)
    to_drive();
    req_0 = 1'b1; we_0 = 1'b1; be_0 = 4'hF; addr_0 = 10'h010; wdata_0 = 32'hDEADBEEF;
    to_check();
    chk("a_wr_gnt", 64'({gnt_1, gnt_0, ram_we}), 64'({2'b01, 4'hF}));
    to_drive();
    we_0 = 1'b0;
    to_check();
    chk("a_rd_gnt", 64'({gnt_1, gnt_0}), 64'(2'b01));
    chk("a_rd_ram", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 4'h0, 10'h010}));
    to_drive();
    req_0 = 1'b0;
    to_check();
    chk("a_rvalid", 64'({rvalid_1, rvalid_0}), 64'(2'b01));
    chk("a_rdata", 64'(rdata), 64'(32'hDEADBEEF));

    // Byte-enable write from M1, then read back
    to_drive();
    req_1 = 1'b1; we_1 = 1'b1; be_1 = 4'hF; addr_1 = 10'h020; wdata_1 = 32'hAAAAAAAA;
    to_check();
    chk("b_fill_gnt", 64'({gnt_1, gnt_0}), 64'(2'b10));
    to_drive();
    be_1 = 4'b0101; wdata_1 = 32'h11223344;
    to_check();
    chk("b_be_we", 64'({gnt_1, ram_we, ram_wdata}), 64'({1'b1, 4'b0101, 32'h11223344}));
    to_drive();
    we_1 = 1'b0;
    to_check();
    chk("b_rd_gnt", 64'({gnt_1, gnt_0}), 64'(2'b10));
    to_drive();
    req_1 = 1'b0;
    to_check();
    chk("b_rvalid", 64'({rvalid_1, rvalid_0}), 64'(2'b10));
    chk("b_rdata", 64'(rdata), 64'(32'hAA22AA44));

    // Asynchronous reset with a pending rvalid and both requesting
    to_drive();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'h010;
    to_check();
    chk("c_gnt", 64'({gnt_1, gnt_0}), 64'(2'b01));
    to_drive();
    req_1 = 1'b1;
    chk("c_rv_before", 64'({rvalid_1, rvalid_0}), 64'(2'b01));
    rst = 1'b0;
    #1;
    chk("c_rv_reset", 64'({rvalid_1, rvalid_0}), 64'(2'b00));
    req_0 = 1'b0; req_1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    to_drive();
    req_0 = 1'b1; req_1 = 1'b1; we_1 = 1'b0;
    to_check();
    chk("c_first_gnt", 64'({gnt_1, gnt_0}), 64'(2'b01));
    to_drive();
    req_0 = 1'b0; req_1 = 1'b0;
    to_check();

    // Reset mid-tenure while M1 has a read in flight
    to_drive();
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'h020;
    to_check();
    chk("d_gnt", 64'({gnt_1, gnt_0}), 64'(2'b10));
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("d_rv_lost", 64'({rvalid_1, rvalid_0}), 64'(2'b00));
    req_1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    to_drive();
    req_0 = 1'b1; req_1 = 1'b1;
    to_check();
    chk("d_after_gnt", 64'({gnt_1, gnt_0}), 64'(2'b01));
    to_drive();
    req_0 = 1'b0; req_1 = 1'b0;

    // Hold limit, early release and priority rotation from the table
    do_reset();
    addr_0 = 10'h000; addr_1 = 10'h001; be_0 = 4'hF; be_1 = 4'hF;
    for (int i = 0; i < 20; i++) begin
      to_drive();
      req_0 = vec[i].r0; req_1 = vec[i].r1; we_0 = vec[i].w0; we_1 = vec[i].w1;
      to_check();
      chk($sformatf("tbl_gnt[%0d]", i), 64'({gnt_1, gnt_0}), 64'(vec[i].g));
      chk($sformatf("tbl_rv[%0d]", i), 64'({rvalid_1, rvalid_0}), 64'(vec[i].rv));
      chk($sformatf("tbl_en[%0d]", i), 64'(ram_en), 64'(|vec[i].g));
    end

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    w = -1;
    for (int i = 0; i < 16; i++) begin
      to_drive();
      req_0 = 1'b1; we_0 = 1'b1; be_0 = 4'hF; addr_0 = 10'(i); wdata_0 = $urandom;
      req_1 = 1'b0;
      rcheck(w);
    end
    for (int i = 0; i < 3000; i++) begin
      to_drive();
      if (!req_0 || w == 0) begin
        req_0   = ($urandom_range(0, 99) < 70);
        we_0    = $urandom_range(0, 1) == 1;
        be_0    = 4'($urandom);
        addr_0  = 10'($urandom_range(0, 15));
        wdata_0 = $urandom;
      end
      if (!req_1 || w == 1) begin
        req_1   = ($urandom_range(0, 99) < 70);
        we_1    = $urandom_range(0, 1) == 1;
        be_1    = 4'($urandom);
        addr_1  = 10'($urandom_range(0, 15));
        wdata_1 = $urandom;
      end
      rcheck(w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
